// File: rtl/light_pkg.sv
// Shared types and constants for the light manager's pattern-select stage.
// Pure declarations; no timing or flow-control implications.
package light_pkg;

  localparam int SEL_W = 6;
  localparam logic [SEL_W-1:0] SEL_MAX = 6'd63;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Returns {wrapped, next_sel} for one modulo-64 advance in the given direction.
  function automatic logic [SEL_W:0] sel_step(input logic [SEL_W-1:0] cur, input logic up);
    logic [SEL_W-1:0] nxt;
    logic             wrapped;
    if (up) begin
      nxt     = cur + SEL_W'(1);
      wrapped = (cur == SEL_MAX);
    end else begin
      nxt     = cur - SEL_W'(1);
      wrapped = (cur == '0);
    end
    return {wrapped, nxt};
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for a synchronous level; pulse is combinational from d vs. last sample.
// Zero-cycle latency, no backpressure; no edge is reported on the first cycle after reset.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic d_q;
  logic armed;

  // armed masks the first post-reset sample so a level held through reset is not an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q   <= 1'b0;
      armed <= 1'b0;
    end else begin
      d_q   <= d;
      armed <= 1'b1;
    end
  end

  assign rise = armed & d & ~d_q;

endmodule

// File: rtl/light_sel_sequencer.sv
// Steps the 6-bit light pattern index at a programmable rate with run/stop, step, direction and load.
// sel/adv/wrap are registered together; no backpressure, load always overrides advances.
module light_sel_sequencer #(
  parameter int TICK_DIV = 25000000,
  parameter int SEL_W    = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic             dir,
  input  logic             load,
  input  logic [SEL_W-1:0] load_val,
  output logic [SEL_W-1:0] sel,
  output logic             running,
  output logic             adv,
  output logic             wrap
);
  import light_pkg::*;

  localparam int PW = ($clog2(TICK_DIV) < 1) ? 1 : $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  state_t           state;
  state_t           state_nxt;
  logic [PW-1:0]    presc;
  logic [PW-1:0]    presc_nxt;
  logic [SEL_W-1:0] sel_nxt;
  logic [SEL_W-1:0] sel_adv;
  logic             adv_nxt;
  logic             wrap_nxt;
  logic             wrap_c;
  logic             start_rise;
  logic             stop_rise;
  logic             step_rise;
  logic             tick;
  logic             step_adv;
  logic             advance;

  rise_detect u_start_rise (.clk(clk), .rst_n(rst_n), .d(start), .rise(start_rise));
  rise_detect u_stop_rise  (.clk(clk), .rst_n(rst_n), .d(stop),  .rise(stop_rise));
  rise_detect u_step_rise  (.clk(clk), .rst_n(rst_n), .d(step),  .rise(step_rise));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    presc_nxt = '0;
    sel_nxt   = sel;
    adv_nxt   = 1'b0;
    wrap_nxt  = 1'b0;

    // Stop dominates start; start in RUN and stop in IDLE fall through as no-ops.
    if (stop_rise) begin
      state_nxt = IDLE;
    end else if (start_rise) begin
      state_nxt = RUN;
    end

    // A stop edge on the terminal count freezes sel rather than taking one last step.
    tick     = (state == RUN) && (presc == PRESC_LAST) && !stop_rise;
    step_adv = (state == IDLE) && step_rise;
    advance  = (tick || step_adv) && !load;

    {wrap_c, sel_adv} = sel_step(sel, dir);

    if (!load && state == RUN && state_nxt == RUN && presc != PRESC_LAST) begin
      presc_nxt = presc + PW'(1);
    end

    if (load) begin
      sel_nxt = load_val;
    end else if (advance) begin
      sel_nxt  = sel_adv;
      adv_nxt  = 1'b1;
      wrap_nxt = wrap_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      sel   <= '0;
      adv   <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      presc <= presc_nxt;
      sel   <= sel_nxt;
      adv   <= adv_nxt;
      wrap  <= wrap_nxt;
    end
  end

  assign running = (state == RUN);

endmodule

// File: tb/tb_light_sel_sequencer.sv
// Directed bench for light_sel_sequencer at TICK_DIV=4; expected values are hand-computed.
module tb_light_sel_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       step;
  logic       dir;
  logic       load;
  logic [5:0] load_val;
  logic [5:0] sel;
  logic       running;
  logic       adv;
  logic       wrap;

  int checks = 0;
  int fails  = 0;

  light_sel_sequencer #(.TICK_DIV(4), .SEL_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .step(step),
    .dir(dir), .load(load), .load_val(load_val),
    .sel(sel), .running(running), .adv(adv), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [5:0] e_sel, input logic e_run,
                         input logic e_adv, input logic e_wrap);
    chk({tag, ".sel"},     {2'b00, sel},     {2'b00, e_sel});
    chk({tag, ".running"}, {7'd0, running},  {7'd0, e_run});
    chk({tag, ".adv"},     {7'd0, adv},      {7'd0, e_adv});
    chk({tag, ".wrap"},    {7'd0, wrap},     {7'd0, e_wrap});
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; step = 1'b0;
    dir = 1'b1; load = 1'b0; load_val = '0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    chk_out("reset", 6'd0, 1'b0, 1'b0, 1'b0);

    // Free run up
    start = 1'b1;
    cyc(1);
    chk_out("run_rise", 6'd0, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    cyc(3);
    chk_out("run_pre1", 6'd0, 1'b1, 1'b0, 1'b0);
    cyc(1);
    chk_out("run_adv1", 6'd1, 1'b1, 1'b1, 1'b0);
    cyc(1);
    chk_out("run_post1", 6'd1, 1'b1, 1'b0, 1'b0);
    cyc(3);
    chk_out("run_adv2", 6'd2, 1'b1, 1'b1, 1'b0);
    cyc(4);
    chk_out("run_adv3", 6'd3, 1'b1, 1'b1, 1'b0);

    // Wrap up
    load = 1'b1; load_val = 6'd62;
    cyc(1);
    chk_out("ld62", 6'd62, 1'b1, 1'b0, 1'b0);
    load = 1'b0;
    cyc(3);
    chk_out("ld62_hold", 6'd62, 1'b1, 1'b0, 1'b0);
    cyc(1);
    chk_out("up_63", 6'd63, 1'b1, 1'b1, 1'b0);
    cyc(4);
    chk_out("up_wrap", 6'd0, 1'b1, 1'b1, 1'b1);
    cyc(1);
    chk_out("up_wrap_end", 6'd0, 1'b1, 1'b0, 1'b0);

    // Wrap down
    dir = 1'b0; load = 1'b1; load_val = 6'd1;
    cyc(1);
    load = 1'b0;
    chk_out("ld1", 6'd1, 1'b1, 1'b0, 1'b0);
    cyc(4);
    chk_out("dn_0", 6'd0, 1'b1, 1'b1, 1'b0);
    cyc(4);
    chk_out("dn_wrap", 6'd63, 1'b1, 1'b1, 1'b1);

    // Load collides with a due advance
    cyc(3);
    dir = 1'b1; load = 1'b1; load_val = 6'd40;
    cyc(1);
    chk_out("ld_collide", 6'd40, 1'b1, 1'b0, 1'b0);
    load = 1'b0;
    cyc(3);
    chk_out("ld_collide_hold", 6'd40, 1'b1, 1'b0, 1'b0);
    cyc(1);
    chk_out("ld_collide_adv", 6'd41, 1'b1, 1'b1, 1'b0);

    // Step edge in RUN is ignored
    step = 1'b1;
    cyc(1);
    step = 1'b0;
    cyc(1);
    chk_out("step_in_run", 6'd41, 1'b1, 1'b0, 1'b0);
    cyc(2);
    chk_out("step_in_run_adv", 6'd42, 1'b1, 1'b1, 1'b0);

    // Stop mid-count at sel=9
    load = 1'b1; load_val = 6'd9;
    cyc(1);
    load = 1'b0;
    cyc(2);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    chk_out("stop", 6'd9, 1'b0, 1'b0, 1'b0);
    cyc(10);
    chk_out("stop_hold", 6'd9, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk_out("restart", 6'd9, 1'b1, 1'b0, 1'b0);
    cyc(3);
    chk_out("restart_pre", 6'd9, 1'b1, 1'b0, 1'b0);
    cyc(1);
    chk_out("restart_adv", 6'd10, 1'b1, 1'b1, 1'b0);

    // Start and stop together from IDLE
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    cyc(1);
    start = 1'b1; stop = 1'b1;
    cyc(1);
    chk_out("start_stop", 6'd10, 1'b0, 1'b0, 1'b0);
    start = 1'b0; stop = 1'b0;
    cyc(1);
    chk_out("start_stop_after", 6'd10, 1'b0, 1'b0, 1'b0);

    // Manual steps in IDLE
    load = 1'b1; load_val = 6'd5;
    cyc(1);
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step = 1'b1;
      cyc(1);
      chk_out("step_adv", 6'(6 + i), 1'b0, 1'b1, 1'b0);
      step = 1'b0;
      cyc(1);
      chk_out("step_gap", 6'(6 + i), 1'b0, 1'b0, 1'b0);
    end
    step = 1'b1;
    cyc(1);
    chk_out("step_hold_adv", 6'd9, 1'b0, 1'b1, 1'b0);
    cyc(9);
    chk_out("step_hold", 6'd9, 1'b0, 1'b0, 1'b0);
    step = 1'b0;

    // Manual step wrapping down
    dir = 1'b0; load = 1'b1; load_val = 6'd0;
    cyc(1);
    load = 1'b0;
    step = 1'b1;
    cyc(1);
    step = 1'b0;
    chk_out("step_wrap_dn", 6'd63, 1'b0, 1'b1, 1'b1);

    // Reset mid-run with sel=17
    dir = 1'b1; load = 1'b1; load_val = 6'd17;
    cyc(1);
    load = 1'b0;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(1);
    chk_out("pre_reset", 6'd17, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    start = 1'b1;
    #1;
    chk_out("mid_reset", 6'd0, 1'b0, 1'b0, 1'b0);
    cyc(2);
    rst_n = 1'b1;
    cyc(5);
    chk_out("held_start", 6'd0, 1'b0, 1'b0, 1'b0);
    start = 1'b0;
    cyc(1);
    start = 1'b1;
    cyc(1);
    chk_out("fresh_start", 6'd0, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    cyc(4);
    chk_out("fresh_adv", 6'd1, 1'b1, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
